decode_queue: RTL and testbench



---
 rtl/decode_queue_pkg.sv | 69 ++++++
 rtl/decode_queue_decoder.sv | 87 ++++++++
 rtl/decode_queue.sv | 132 +++++++++++++
 tb/tb_decode_queue.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_queue_pkg.sv
// Shared types for the decode stage: instruction/immediate widths, control word, queue entry.
package decode_queue_pkg;

    localparam int unsigned INSTRUCTION_SIZE = 32;
    localparam int unsigned DATA_SIZE        = 32;
    localparam int unsigned REG_W            = 5;
    localparam int unsigned IMM_W            = 32;

    typedef logic [REG_W-1:0] Register;
    typedef logic [IMM_W-1:0] Immediate;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
    } alu_op_e;

    typedef struct packed {
        logic    regwr;
        logic    alusrc;
        logic    memrd;
        logic    memwr;
        logic    mem2reg;
        logic    branch;
        logic    jump;
        logic    branch_prediction;
        logic    ecall;
        logic    unsupported;
        alu_op_e aluop;
    } control_bits;

    localparam int unsigned CONTROL_BITS_SIZE = $bits(control_bits);

    typedef struct packed {
        logic [INSTRUCTION_SIZE-1:0] instruction;
        logic [DATA_SIZE-1:0]        pc;
        logic                        branch_taken;
    } fetch_entry_t;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [INSTRUCTION_SIZE-1:0] ECALL_INSTR = 32'h0000_0073;

    // funct3/funct7 to ALU operation; SUB only exists for register-register ops.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                           input logic is_reg);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// Single-instruction RV32I decoder: register specifiers, immediate and control word.
module decoder
    import decode_queue_pkg::*;
(
    input  logic [INSTRUCTION_SIZE-1:0] instruction_i,
    input  logic                        branch_taken_i,
    output Register                     rs1_o,
    output Register                     rs2_o,
    output Register                     rd_o,
    output Immediate                    imm_o,
    output control_bits                 ctrl_o
);

    logic [6:0]     opcode;
    logic [2:0]     f3;
    logic           f7b5;
    logic [31:0]    ins;

    assign ins    = instruction_i;
    assign opcode = ins[6:0];
    assign f3     = ins[14:12];
    assign f7b5   = ins[30];
    assign rd_o   = ins[11:7];
    assign rs1_o  = ins[19:15];
    assign rs2_o  = ins[24:20];

    always_comb begin
        imm_o                    = {{20{ins[31]}}, ins[31:20]};
        ctrl_o                   = '0;
        ctrl_o.aluop             = ALU_ADD;
        ctrl_o.branch_prediction = branch_taken_i;
        case (opcode)
            OPC_OP_IMM: begin
                ctrl_o.regwr  = 1'b1;
                ctrl_o.alusrc = 1'b1;
                ctrl_o.aluop  = alu_decode(f3, f7b5, 1'b0);
            end
            OPC_OP: begin
                ctrl_o.regwr = 1'b1;
                ctrl_o.aluop = alu_decode(f3, f7b5, 1'b1);
            end
            OPC_LOAD: begin
                ctrl_o.regwr   = 1'b1;
                ctrl_o.alusrc  = 1'b1;
                ctrl_o.memrd   = 1'b1;
                ctrl_o.mem2reg = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.alusrc = 1'b1;
                ctrl_o.memwr  = 1'b1;
                imm_o         = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            OPC_BRANCH: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluop  = ALU_SUB;
                imm_o         = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            OPC_JAL: begin
                ctrl_o.regwr = 1'b1;
                ctrl_o.jump  = 1'b1;
                imm_o        = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            OPC_JALR: begin
                ctrl_o.regwr  = 1'b1;
                ctrl_o.jump   = 1'b1;
                ctrl_o.alusrc = 1'b1;
            end
            OPC_LUI: begin
                ctrl_o.regwr  = 1'b1;
                ctrl_o.alusrc = 1'b1;
                ctrl_o.aluop  = ALU_PASS_B;
                imm_o         = {ins[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                ctrl_o.regwr  = 1'b1;
                ctrl_o.alusrc = 1'b1;
                imm_o         = {ins[31:12], 12'b0};
            end
            OPC_SYSTEM: begin
                if (instruction_i == ECALL_INSTR) ctrl_o.ecall       = 1'b1;
                else                              ctrl_o.unsupported = 1'b1;
            end
            default: ctrl_o.unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Multi-wide decode queue: compacting enqueue of a fetch bundle, in-order decode of the head
// entries with ECALL serialisation, flush/reset clearing all pointers.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          flush,
    input  logic [FETCH_WIDTH-1:0]                        in_valid,
    input  logic [FETCH_WIDTH-1:0][INSTRUCTION_SIZE-1:0]  in_instruction,
    input  logic [FETCH_WIDTH-1:0][DATA_SIZE-1:0]         in_pc,
    input  logic [FETCH_WIDTH-1:0]                        in_branch_taken,
    output logic                                          in_ready,
    output logic [ISSUE_WIDTH-1:0]                        out_valid,
    output logic [ISSUE_WIDTH-1:0][DATA_SIZE-1:0]         out_pc,
    output logic [ISSUE_WIDTH-1:0][REG_W-1:0]             out_rs1,
    output logic [ISSUE_WIDTH-1:0][REG_W-1:0]             out_rs2,
    output logic [ISSUE_WIDTH-1:0][REG_W-1:0]             out_rd,
    output logic [ISSUE_WIDTH-1:0][IMM_W-1:0]             out_imm,
    output logic [ISSUE_WIDTH-1:0][CONTROL_BITS_SIZE-1:0] out_ctrl_bits,
    input  logic                                          out_ready,
    output logic [$clog2(DEPTH):0]                        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t                      mem_q [DEPTH];
    logic [PTR_W-1:0]                  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic [CNT_W-1:0]                  pushed, valid_cnt;
    logic [FETCH_WIDTH-1:0][PTR_W-1:0] wr_idx;
    logic                              push;
    logic                              blocked;
    fetch_entry_t                      rd_entry [ISSUE_WIDTH];
    control_bits                       dec_ctrl [ISSUE_WIDTH];

    assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);
    assign push     = in_ready && (|in_valid);
    assign count    = count_q;

    // Compaction: each valid lane lands after all lower valid lanes.
    always_comb begin
        pushed = '0;
        wr_idx = '0;
        for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
            wr_idx[i] = tail_q + PTR_W'(pushed);
            pushed    = pushed + CNT_W'(in_valid[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            for (int i = 0; i < int'(FETCH_WIDTH); i++) begin
                if (in_valid[i]) begin
                    mem_q[wr_idx[i]] <= '{instruction:  in_instruction[i],
                                          pc:           in_pc[i],
                                          branch_taken: in_branch_taken[i]};
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            rd_entry[i] = mem_q[head_q + PTR_W'(i)];
        end
    end

    for (genvar g = 0; g < int'(ISSUE_WIDTH); g++) begin : g_dec
        decoder u_decoder (
            .instruction_i  (rd_entry[g].instruction),
            .branch_taken_i (rd_entry[g].branch_taken),
            .rs1_o          (out_rs1[g]),
            .rs2_o          (out_rs2[g]),
            .rd_o           (out_rd[g]),
            .imm_o          (out_imm[g]),
            .ctrl_o         (dec_ctrl[g])
        );
        assign out_pc[g]        = rd_entry[g].pc;
        assign out_ctrl_bits[g] = dec_ctrl[g];
    end

    // Lanes after an ECALL are held back so the ECALL retires alone at the group end.
    always_comb begin
        blocked   = 1'b0;
        valid_cnt = '0;
        out_valid = '0;
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            out_valid[i] = (count_q > CNT_W'(i)) && !blocked;
            if (out_valid[i] && dec_ctrl[i].ecall) blocked = 1'b1;
            valid_cnt = valid_cnt + CNT_W'(out_valid[i]);
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                tail_d  = tail_q + PTR_W'(pushed);
                count_d = count_d + pushed;
            end
            if (out_ready) begin
                head_d  = head_q + PTR_W'(valid_cnt);
                count_d = count_d - valid_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed and scoreboard checks for decode_queue with FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic                                clk = 1'b0;
    logic                                reset, flush, out_ready;
    logic [1:0]                          in_valid, in_branch_taken, out_valid;
    logic                                in_ready;
    logic [1:0][31:0]                    in_instruction, in_pc, out_pc, out_imm;
    logic [1:0][4:0]                     out_rs1, out_rs2, out_rd;
    logic [1:0][CONTROL_BITS_SIZE-1:0]   out_ctrl_bits;
    logic [3:0]                          count;

    int vectors = 0;
    int miscompares = 0;

    decode_queue #(.FETCH_WIDTH(2), .ISSUE_WIDTH(2), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_instruction(in_instruction), .in_pc(in_pc),
        .in_branch_taken(in_branch_taken), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd(out_rd), .out_imm(out_imm), .out_ctrl_bits(out_ctrl_bits),
        .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] pc0, pc1;
        logic        ordy;
        logic [3:0]  e_cnt;
        logic        e_rdy;
        logic [1:0]  e_ov;
        logic [31:0] e_pc0, e_pc1;
    } vec_t;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    function automatic control_bits ctl(input int lane);
        return control_bits'(out_ctrl_bits[lane]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic ordy, input logic fl);
        in_valid          = v;
        in_instruction[0] = i0;
        in_pc[0]          = p0;
        in_instruction[1] = i1;
        in_pc[1]          = p1;
        out_ready         = ordy;
        flush             = fl;
    endtask

    vec_t tbl [13];

    logic [31:0] q_pc [$];
    logic [31:0] q_ins [$];

    initial begin
        // fill/drain then compaction; expectations are the state seen at the start of each cycle
        tbl[0]  = '{2'b11, 32'h100, 32'h104, 1'b0, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0};
        tbl[1]  = '{2'b11, 32'h108, 32'h10C, 1'b0, 4'd2, 1'b1, 2'b11, 32'h100, 32'h104};
        tbl[2]  = '{2'b11, 32'h110, 32'h114, 1'b0, 4'd4, 1'b1, 2'b11, 32'h100, 32'h104};
        tbl[3]  = '{2'b11, 32'h118, 32'h11C, 1'b0, 4'd6, 1'b1, 2'b11, 32'h100, 32'h104};
        tbl[4]  = '{2'b11, 32'h120, 32'h124, 1'b0, 4'd8, 1'b0, 2'b11, 32'h100, 32'h104};
        tbl[5]  = '{2'b11, 32'h120, 32'h124, 1'b1, 4'd8, 1'b0, 2'b11, 32'h100, 32'h104};
        tbl[6]  = '{2'b11, 32'h120, 32'h124, 1'b1, 4'd6, 1'b1, 2'b11, 32'h108, 32'h10C};
        tbl[7]  = '{2'b00, 32'h0,   32'h0,   1'b1, 4'd6, 1'b1, 2'b11, 32'h110, 32'h114};
        tbl[8]  = '{2'b00, 32'h0,   32'h0,   1'b1, 4'd4, 1'b1, 2'b11, 32'h118, 32'h11C};
        tbl[9]  = '{2'b00, 32'h0,   32'h0,   1'b1, 4'd2, 1'b1, 2'b11, 32'h120, 32'h124};
        tbl[10] = '{2'b10, 32'h2000, 32'h2004, 1'b0, 4'd0, 1'b1, 2'b00, 32'h0, 32'h0};
        tbl[11] = '{2'b00, 32'h0,   32'h0,   1'b1, 4'd1, 1'b1, 2'b01, 32'h2004, 32'h0};
        tbl[12] = '{2'b00, 32'h0,   32'h0,   1'b0, 4'd0, 1'b1, 2'b00, 32'h0,   32'h0};

        in_branch_taken = 2'b00;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_count", 32'(count), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // basic decode of addi x1,x0,5
        drive(2'b01, 32'h0050_0093, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("basic_out_valid", 32'(out_valid), 32'h1);
        check("basic_pc", out_pc[0], 32'h1000);
        check("basic_rd", 32'(out_rd[0]), 32'd1);
        check("basic_rs1", 32'(out_rs1[0]), 32'd0);
        check("basic_imm", out_imm[0], 32'd5);
        check("basic_regwr", 32'(ctl(0).regwr), 32'd1);
        check("basic_alusrc", 32'(ctl(0).alusrc), 32'd1);
        check("basic_aluop", 32'(ctl(0).aluop), 32'(ALU_ADD));
        check("basic_count", 32'(count), 32'd1);
        step();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("basic_popped_count", 32'(count), 32'd0);

        for (int i = 0; i < 13; i++) begin
            check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov[0]) check($sformatf("tbl%0d_pc0", i), out_pc[0], tbl[i].e_pc0);
            if (tbl[i].e_ov[1]) check($sformatf("tbl%0d_pc1", i), out_pc[1], tbl[i].e_pc1);
            drive(tbl[i].v, addi(5'd1, tbl[i].pc0[11:0]), tbl[i].pc0,
                  addi(5'd1, tbl[i].pc1[11:0]), tbl[i].pc1, tbl[i].ordy, 1'b0);
            step();
        end

        // ECALL serialisation: ecall then add x3,x1,x2 (predicted taken)
        in_branch_taken = 2'b10;
        drive(2'b11, ECALL_INSTR, 32'h3000, 32'h0020_81B3, 32'h3004, 1'b0, 1'b0);
        step();
        in_branch_taken = 2'b00;
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("ecall_count", 32'(count), 32'd2);
        check("ecall_out_valid", 32'(out_valid), 32'h1);
        check("ecall_bit", 32'(ctl(0).ecall), 32'd1);
        check("ecall_pc", out_pc[0], 32'h3000);
        step();
        check("add_out_valid", 32'(out_valid), 32'h1);
        check("add_pc", out_pc[0], 32'h3004);
        check("add_ecall", 32'(ctl(0).ecall), 32'd0);
        check("add_rd", 32'(out_rd[0]), 32'd3);
        check("add_rs2", 32'(out_rs2[0]), 32'd2);
        check("add_aluop", 32'(ctl(0).aluop), 32'(ALU_ADD));
        check("add_branch_pred", 32'(ctl(0).branch_prediction), 32'd1);
        step();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("ecall_drained", 32'(count), 32'd0);

        // flush beats a same-cycle push and pop
        drive(2'b11, addi(5'd1, 12'h0), 32'h4000, addi(5'd1, 12'h4), 32'h4004, 1'b0, 1'b0);
        step();
        drive(2'b11, addi(5'd1, 12'h8), 32'h4008, addi(5'd1, 12'hC), 32'h400C, 1'b0, 1'b0);
        step();
        check("preflush_count", 32'(count), 32'd4);
        drive(2'b11, addi(5'd1, 12'h50), 32'h5000, addi(5'd1, 12'h54), 32'h5004, 1'b1, 1'b1);
        step();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        drive(2'b11, addi(5'd1, 12'h60), 32'h6000, addi(5'd1, 12'h64), 32'h6004, 1'b0, 1'b0);
        step();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("postflush_pc0", out_pc[0], 32'h6000);
        check("postflush_pc1", out_pc[1], 32'h6004);
        check("postflush_count", 32'(count), 32'd2);
        step();
        drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // random traffic against a queue model
        begin
            int          head_idx, wraps, n;
            logic [31:0] pc_next;
            logic [1:0]  v;
            logic        ordy, acc;
            logic [1:0][31:0] ins, pcs;
            head_idx = 0;
            wraps    = 0;
            pc_next  = 32'h7000;
            for (int cyc = 0; cyc < 60; cyc++) begin
                n = (q_pc.size() < 2) ? q_pc.size() : 2;
                if (n == 2 && q_ins[0] == ECALL_INSTR) n = 1;
                check("rnd_count", 32'(count), 32'(q_pc.size()));
                check("rnd_in_ready", 32'(in_ready), 32'(8 - q_pc.size() >= 2));
                check("rnd_out_valid", 32'(out_valid), (n == 0) ? 32'h0 : (n == 1) ? 32'h1 : 32'h3);
                for (int l = 0; l < n; l++) begin
                    check("rnd_pc", out_pc[l], q_pc[l]);
                    check("rnd_ecall", 32'(ctl(l).ecall), 32'(q_ins[l] == ECALL_INSTR));
                    if (q_ins[l] != ECALL_INSTR) check("rnd_imm", out_imm[l], 32'(q_pc[l][11:0]));
                end
                v    = 2'($urandom_range(0, 3));
                ordy = ($urandom_range(0, 3) != 0);
                acc  = (8 - q_pc.size() >= 2) && (v != 2'b00);
                pcs  = {32'hDEAD_0004, 32'hDEAD_0000};
                ins  = {addi(5'd1, 12'h0), addi(5'd1, 12'h0)};
                begin
                    logic [31:0] p;
                    p = pc_next;
                    for (int l = 0; l < 2; l++) begin
                        if (v[l]) begin
                            pcs[l] = p;
                            ins[l] = ($urandom_range(0, 7) == 0) ? ECALL_INSTR : addi(5'd1, p[11:0]);
                            p = p + 32'd4;
                        end
                    end
                    if (acc) pc_next = p;
                end
                drive(v, ins[0], pcs[0], ins[1], pcs[1], ordy, 1'b0);
                if (ordy) begin
                    for (int l = 0; l < n; l++) begin
                        void'(q_pc.pop_front());
                        void'(q_ins.pop_front());
                        if (head_idx == 7) wraps++;
                        head_idx = (head_idx + 1) % 8;
                    end
                end
                if (acc) begin
                    for (int l = 0; l < 2; l++) begin
                        if (v[l]) begin
                            q_pc.push_back(pcs[l]);
                            q_ins.push_back(ins[l]);
                        end
                    end
                end
                step();
            end
            drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
            check("rnd_final_count", 32'(count), 32'(q_pc.size()));
            check("rnd_head_wraps_ge3", 32'(wraps >= 3), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
